// File: rtl/wf8_regfile_pkg.sv
//==== wf8_regfile_pkg -- shared types for the WF8 register file ====== rev 1.0 ====
`default_nettype none

package wf8_regfile_pkg;

  localparam int DEF_BIT_COUNT = 8;
  localparam int DEF_REG_COUNT = 8;
  localparam int DEF_SP_RESET  = 'hFF;

  typedef logic [$clog2(DEF_REG_COUNT)-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    SP_NOP  = 2'd0,
    SP_PUSH = 2'd1,
    SP_POP  = 2'd2,
    SP_LOAD = 2'd3
  } sp_op_e;

  // Load dominates; simultaneous push and pop cancel out to a no-op.
  function automatic sp_op_e decode_sp_op(input logic load, input logic push, input logic pop);
    if (load)             return SP_LOAD;
    else if (push && !pop) return SP_PUSH;
    else if (pop && !push) return SP_POP;
    else                   return SP_NOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_file_sp_sp_counter.sv
//==== sp_counter -- saturating stack pointer with sticky flags ====== rev 1.0 ====
`default_nettype none

module sp_counter
  import wf8_regfile_pkg::*;
#(
  parameter int                   BIT_COUNT = DEF_BIT_COUNT,
  parameter logic [BIT_COUNT-1:0] SP_RESET  = BIT_COUNT'(DEF_SP_RESET)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  sp_op_e               op,
  input  logic [BIT_COUNT-1:0] load_data,
  input  logic                 flag_clr,
  output logic [BIT_COUNT-1:0] sp,
  output logic                 overflow,
  output logic                 underflow
);

  logic [BIT_COUNT-1:0] sp_next;
  logic                 set_ovf;
  logic                 set_unf;

  always_comb begin
    sp_next = sp;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    unique case (op)
      SP_LOAD: sp_next = load_data;
      SP_PUSH: begin
        if (sp == '0) set_ovf = 1'b1;
        else          sp_next = sp - BIT_COUNT'(1);
      end
      SP_POP: begin
        if (sp == SP_RESET) set_unf = 1'b1;
        else                sp_next = sp + BIT_COUNT'(1);
      end
      default: ;
    endcase
  end

  // A flag set in the same cycle as a clear must survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= SP_RESET;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      overflow  <= set_ovf | (overflow  & ~flag_clr);
      underflow <= set_unf | (underflow & ~flag_clr);
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_file_sp.sv
//==== register_file_sp -- 2R/1W register file with bypass and stack pointer == rev 1.0 ==
`default_nettype none

module register_file_sp
  import wf8_regfile_pkg::*;
#(
  parameter int                   BIT_COUNT = DEF_BIT_COUNT,
  parameter int                   REG_COUNT = DEF_REG_COUNT,
  parameter int                   ZERO_REG  = 0,
  parameter logic [BIT_COUNT-1:0] SP_RESET  = BIT_COUNT'(DEF_SP_RESET)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [$clog2(REG_COUNT)-1:0] waddr,
  input  logic [BIT_COUNT-1:0]         wdata,
  input  logic [$clog2(REG_COUNT)-1:0] raddr_a,
  input  logic [$clog2(REG_COUNT)-1:0] raddr_b,
  output logic [BIT_COUNT-1:0]         rdata_a,
  output logic [BIT_COUNT-1:0]         rdata_b,
  input  logic                         sp_push,
  input  logic                         sp_pop,
  input  logic                         sp_load,
  output logic [BIT_COUNT-1:0]         sp,
  output logic                         sp_overflow,
  output logic                         sp_underflow,
  input  logic                         sp_flag_clr
);

  logic [BIT_COUNT-1:0] regs [REG_COUNT];
  logic                 write_ok;
  sp_op_e               sp_op;

  // Writes to r0 are discarded when it is hardwired, so r0 stays at its reset value of 0.
  assign write_ok = we && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (write_ok) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (write_ok && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (write_ok && (waddr == raddr_b)) ? wdata : regs[raddr_b];

  assign sp_op = decode_sp_op(sp_load, sp_push, sp_pop);

  sp_counter #(
    .BIT_COUNT (BIT_COUNT),
    .SP_RESET  (SP_RESET)
  ) u_sp_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (sp_op),
    .load_data (wdata),
    .flag_clr  (sp_flag_clr),
    .sp        (sp),
    .overflow  (sp_overflow),
    .underflow (sp_underflow)
  );

endmodule

`default_nettype wire

// File: tb/tb_register_file_sp.sv
//==== tb_register_file_sp -- randomized reference-model bench for register_file_sp == rev 1.0 ==
`default_nettype none

module tb_register_file_sp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [2:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [2:0] raddr_a = '0;
  logic [2:0] raddr_b = '0;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       sp_push = 1'b0;
  logic       sp_pop = 1'b0;
  logic       sp_load = 1'b0;
  logic [7:0] sp;
  logic       sp_overflow;
  logic       sp_underflow;
  logic       sp_flag_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [7:0] m_regs [8];
  logic [7:0] m_sp;
  bit         m_ovf;
  bit         m_unf;

  register_file_sp #(
    .BIT_COUNT (8),
    .REG_COUNT (8),
    .ZERO_REG  (1),
    .SP_RESET  (8'hFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr_a      (raddr_a),
    .raddr_b      (raddr_b),
    .rdata_a      (rdata_a),
    .rdata_b      (rdata_b),
    .sp_push      (sp_push),
    .sp_pop       (sp_pop),
    .sp_load      (sp_load),
    .sp           (sp),
    .sp_overflow  (sp_overflow),
    .sp_underflow (sp_underflow),
    .sp_flag_clr  (sp_flag_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    m_sp  = 8'hFF;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  function automatic logic [7:0] exp_read(input logic [2:0] addr);
    if (we && waddr == addr && waddr != 3'd0) return wdata;
    return m_regs[addr];
  endfunction

  // Next state from the architectural rules for one rising edge.
  task automatic model_step();
    bit set_o = 1'b0;
    bit set_u = 1'b0;
    if (we && waddr != 3'd0) m_regs[waddr] = wdata;
    if (sp_load) m_sp = wdata;
    else if (sp_push && !sp_pop) begin
      if (m_sp == 8'h00) set_o = 1'b1;
      else m_sp = m_sp - 8'd1;
    end else if (sp_pop && !sp_push) begin
      if (m_sp == 8'hFF) set_u = 1'b1;
      else m_sp = m_sp + 8'd1;
    end
    m_ovf = set_o | (m_ovf & !sp_flag_clr);
    m_unf = set_u | (m_unf & !sp_flag_clr);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".sp"},  {24'd0, sp}, {24'd0, m_sp});
    check({tag, ".ovf"}, {31'd0, sp_overflow}, {31'd0, m_ovf});
    check({tag, ".unf"}, {31'd0, sp_underflow}, {31'd0, m_unf});
  endtask

  // Inputs are applied at posedge+1; this settles and checks the read ports.
  task automatic settle_reads(input string tag);
    #1;
    check({tag, ".rda"}, {24'd0, rdata_a}, {24'd0, exp_read(raddr_a)});
    check({tag, ".rdb"}, {24'd0, rdata_b}, {24'd0, exp_read(raddr_b)});
  endtask

  task automatic clock_and_check(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle_inputs();
    we = 1'b0; sp_push = 1'b0; sp_pop = 1'b0; sp_load = 1'b0; sp_flag_clr = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state: all registers read as zero on both ports
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      raddr_b = 3'(7 - i);
      #1;
      check("reset.rda", {24'd0, rdata_a}, 32'h00);
      check("reset.rdb", {24'd0, rdata_b}, 32'h00);
    end
    check("reset.sp", {24'd0, sp}, 32'hFF);
    check("reset.flags", {30'd0, sp_overflow, sp_underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write-to-read bypass, then the registered value
    we = 1'b1; waddr = 3'd3; wdata = 8'hA5; raddr_a = 3'd3; raddr_b = 3'd3;
    settle_reads("bypass");
    check("bypass.rda_const", {24'd0, rdata_a}, 32'hA5);
    clock_and_check("bypass");
    idle_inputs();
    settle_reads("after_write");
    check("after_write.rda_const", {24'd0, rdata_a}, 32'hA5);
    clock_and_check("after_write");

    // Hardwired zero register
    we = 1'b1; waddr = 3'd0; wdata = 8'h55; raddr_a = 3'd0; raddr_b = 3'd0;
    settle_reads("zr_wr");
    check("zr_wr.rda_const", {24'd0, rdata_a}, 32'h00);
    clock_and_check("zr_wr");
    idle_inputs();
    settle_reads("zr_rd");
    check("zr_rd.rdb_const", {24'd0, rdata_b}, 32'h00);
    clock_and_check("zr_rd");
    we = 1'b1; waddr = 3'd1; wdata = 8'h55; raddr_a = 3'd1; raddr_b = 3'd1;
    settle_reads("r1_wr");
    clock_and_check("r1_wr");
    idle_inputs();
    settle_reads("r1_rd");
    check("r1_rd.rda_const", {24'd0, rdata_a}, 32'h55);
    check("r1_rd.rdb_const", {24'd0, rdata_b}, 32'h55);
    clock_and_check("r1_rd");

    // Drain the stack pointer down to zero
    sp_push = 1'b1;
    for (int i = 0; i < 255; i++) begin
      settle_reads("push");
      clock_and_check("push");
    end
    check("push255.sp_const", {24'd0, sp}, 32'h00);
    check("push255.ovf_const", {31'd0, sp_overflow}, 32'd0);
    settle_reads("push_sat");
    clock_and_check("push_sat");
    check("push_sat.sp_const", {24'd0, sp}, 32'h00);
    check("push_sat.ovf_const", {31'd0, sp_overflow}, 32'd1);
    // Set and clear together: set wins
    sp_flag_clr = 1'b1;
    settle_reads("set_clr");
    clock_and_check("set_clr");
    check("set_clr.ovf_const", {31'd0, sp_overflow}, 32'd1);
    sp_push = 1'b0;
    settle_reads("clr");
    clock_and_check("clr");
    check("clr.ovf_const", {31'd0, sp_overflow}, 32'd0);
    idle_inputs();

    // Pop at the reset value saturates
    sp_load = 1'b1; wdata = 8'hFF;
    settle_reads("ld_ff");
    clock_and_check("ld_ff");
    sp_load = 1'b0; sp_pop = 1'b1;
    settle_reads("pop_sat");
    clock_and_check("pop_sat");
    check("pop_sat.sp_const", {24'd0, sp}, 32'hFF);
    check("pop_sat.unf_const", {31'd0, sp_underflow}, 32'd1);
    sp_pop = 1'b0; sp_load = 1'b1; wdata = 8'h80;
    settle_reads("ld_80");
    clock_and_check("ld_80");
    sp_load = 1'b0; sp_push = 1'b1; sp_pop = 1'b1;
    settle_reads("push_pop");
    clock_and_check("push_pop");
    check("push_pop.sp_const", {24'd0, sp}, 32'h80);
    sp_pop = 1'b0; sp_load = 1'b1; wdata = 8'h10; we = 1'b1; waddr = 3'd6;
    settle_reads("ld_push");
    clock_and_check("ld_push");
    check("ld_push.sp_const", {24'd0, sp}, 32'h10);
    idle_inputs();

    // Asynchronous reset between edges after writes and pushes
    we = 1'b1; waddr = 3'd2; wdata = 8'h77; sp_push = 1'b1;
    settle_reads("pre_rst");
    clock_and_check("pre_rst");
    idle_inputs();
    raddr_a = 3'd3; raddr_b = 3'd2;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst.rda", {24'd0, rdata_a}, 32'h00);
    check("async_rst.rdb", {24'd0, rdata_b}, 32'h00);
    check_state("async_rst");
    check("async_rst.sp_const", {24'd0, sp}, 32'hFF);
    #1;
    rst_n = 1'b1;
    we = 1'b1; waddr = 3'd5; wdata = 8'h3C; raddr_a = 3'd5;
    #1;
    clock_and_check("post_rst_wr");
    idle_inputs();
    settle_reads("post_rst_rd");
    check("post_rst_rd.rda_const", {24'd0, rdata_a}, 32'h3C);
    clock_and_check("post_rst_rd");

    // Randomized traffic with phased push/pop bias to reach both saturation ends
    for (int c = 0; c < 1600; c++) begin
      int r;
      int push_pct;
      push_pct = ((c / 400) % 2 == 0) ? 70 : 20;
      we      = ($urandom_range(0, 99) < 50);
      waddr   = 3'($urandom_range(0, 7));
      wdata   = 8'($urandom);
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      raddr_b = 3'($urandom_range(0, 7));
      r       = $urandom_range(0, 99);
      sp_load = (r < 2);
      sp_push = ($urandom_range(0, 99) < push_pct);
      sp_pop  = ($urandom_range(0, 99) < (90 - push_pct));
      sp_flag_clr = ($urandom_range(0, 99) < 5);
      settle_reads("rand");
      clock_and_check("rand");
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
